cmd_fetch: RTL
==============

CMD_FETCH -- requirements
Module: cmd_fetch

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the instruction-address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the command-word width.
REQ-003 clk  in  1  SHALL be the rising-edge clock for all state.
REQ-004 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 start  in  1  SHALL begin fetching from ip_start; sampled only in IDLE.
REQ-006 ip_start  in  ADDR_W  SHALL be the first fetch address.
REQ-007 jmp  in  1  SHALL be a one-cycle redirect pulse.
REQ-008 jmp_addr  in  ADDR_W  SHALL be the redirect target.
REQ-009 mem_rd  out  1  SHALL be the memory read request, held high for one cycle per request.
REQ-010 mem_addr  out  ADDR_W  SHALL be the read address, valid while mem_rd=1.
REQ-011 mem_ack  in  1  SHALL mark mem_data valid for one cycle; at most one request is outstanding.
REQ-012 mem_data  in  DATA_W  SHALL be the read data.
REQ-013 cmd_valid  out  1  SHALL indicate that command/cmd_ip hold a buffered command.
REQ-014 command  out  DATA_W  SHALL be the command word at the FIFO head, fed to the state sequencer.
REQ-015 cmd_ip  out  ADDR_W  SHALL be the fetch address of the head command.
REQ-016 cmd_take  in  1  SHALL pop the head when the sequencer has finished the command (FINISH).
REQ-017 busy  out  1  SHALL be high whenever the state is not IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT, DRAIN and STALL; mem_rd=1 exactly when the state is REQ, and mem_addr=fetch_ip.
REQ-019 A 2-entry FIFO of {command, address} SHALL hold fetched words; cmd_valid=(count!=0); command/cmd_ip SHALL be driven from the head entry.
REQ-020 IDLE with start=1 SHALL set fetch_ip=ip_start and enter REQ; start outside IDLE SHALL be ignored.
REQ-021 REQ SHALL always go to WAIT after one cycle.
REQ-022 WAIT with mem_ack=1 SHALL push {mem_data, fetch_ip}, set fetch_ip=fetch_ip+1 (wrapping modulo 2^ADDR_W), then go to REQ if the FIFO count after push and pop is <2, otherwise STALL.
REQ-023 WAIT with mem_ack=0 SHALL stay in WAIT, with no timeout.
REQ-024 STALL SHALL go to REQ in the cycle after count drops below 2.
REQ-025 A pop SHALL occur on cmd_valid & cmd_take; cmd_take with cmd_valid=0 SHALL be ignored.
REQ-026 A simultaneous push and pop SHALL leave count unchanged and keep FIFO order.
REQ-027 Latency: start at edge N SHALL give mem_rd=1 in cycle N+1; mem_ack sampled at edge M SHALL give cmd_valid=1 from cycle M+1.
REQ-028 jmp=1 in REQ/WAIT/DRAIN/STALL SHALL flush the FIFO (count=0; any same-cycle pop or push is discarded) and set fetch_ip=jmp_addr.
REQ-029 jmp next-state: from REQ, or from WAIT with mem_ack=0, SHALL go to DRAIN; from WAIT with mem_ack=1 SHALL go to REQ (the ack data is dropped); from STALL SHALL go to REQ; from DRAIN SHALL stay in DRAIN with the new fetch_ip.
REQ-030 DRAIN SHALL drop the next mem_ack without pushing or incrementing, then go to REQ.
REQ-031 jmp in IDLE SHALL be ignored.
REQ-032 Any next-state or datapath update SHALL occur only on the rising clk edge; all outputs are Moore/registered-derived, with no combinational path from inputs.

Reset
REQ-033 rst=1 SHALL force, at the next edge and regardless of state: state=IDLE, count=0, fetch_ip=0, FIFO storage=0, mem_rd=0, cmd_valid=0, command=0, cmd_ip=0, busy=0.
REQ-034 rst SHALL take priority over start, jmp, mem_ack and cmd_take.
REQ-035 A mem_ack arriving in the first cycle after a mid-operation reset SHALL be ignored.

Verification
REQ-036 Reset then start with ip_start=0x100, memory returning data 0xA0000000+addr with 1-cycle ack, cmd_take=0 -> mem_addr sequence is 0x100 then 0x101; FSM enters STALL; head command=0xA0000100, cmd_ip=0x100.
REQ-037 From that full FIFO, pulse cmd_take once -> next command=0xA0000101; mem_rd=1 one cycle later with addr 0x102.
REQ-038 jmp with jmp_addr=0x200 while in WAIT, ack 3 cycles later -> that ack is dropped; cmd_valid=0; next mem_addr=0x200; first command after the jump is 0xA0000200.
REQ-039 ip_start=0xFFFFFFFF with ADDR_W=32 -> second fetch address is 0x00000000.
REQ-040 Push and cmd_take in the same cycle with count=1 -> count stays 1 and the head becomes the newly pushed word.
REQ-041 Assert rst while in WAIT with two entries buffered -> the next cycle has cmd_valid=0, busy=0, mem_rd=0, and a later ack has no effect.

Source files
------------

// File: rtl/cmd_fetch.sv
// cmd_fetch: instruction-word fetcher with a 2-entry {command, address} buffer.
// Issues one memory read at a time, buffers returned words for the sequencer,
// and supports jump redirects that flush the buffer and discard a stale ack.
module cmd_fetch #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] ip_start,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic              cmd_valid,
  output logic [DATA_W-1:0] command,
  output logic [ADDR_W-1:0] cmd_ip,
  input  logic              cmd_take,
  output logic              busy
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_STALL = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  fetch_ip_q, fetch_ip_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0]  data_q [DEPTH];
  logic [ADDR_W-1:0]  addr_q [DEPTH];

  logic               flush_c;
  logic               push_c;
  logic               pop_c;
  logic [CNT_W-1:0]   count_pp_c;

  // Buffer control: a redirect outside IDLE overrides any push or pop.
  always_comb begin
    flush_c    = jmp && (state_q != S_IDLE);
    push_c     = (state_q == S_WAIT) && mem_ack && !flush_c;
    pop_c      = (count_q != '0) && cmd_take && !flush_c;
    count_pp_c = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_REQ;
      end
      S_REQ: begin
        state_d = jmp ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (jmp) begin
          state_d = mem_ack ? S_REQ : S_DRAIN;
        end else if (mem_ack) begin
          state_d = (count_pp_c < CNT_W'(DEPTH)) ? S_REQ : S_STALL;
        end
      end
      S_DRAIN: begin
        if (!jmp && mem_ack) state_d = S_REQ;
      end
      S_STALL: begin
        if (jmp || (count_q < CNT_W'(DEPTH))) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    mem_rd    = (state_q == S_REQ);
    busy      = (state_q != S_IDLE);
    mem_addr  = fetch_ip_q;
    cmd_valid = (count_q != '0);
    command   = data_q[rd_ptr_q];
    cmd_ip    = addr_q[rd_ptr_q];
  end

  // Fetch pointer and buffer bookkeeping next-state.
  always_comb begin
    fetch_ip_d = fetch_ip_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if ((state_q == S_IDLE) && start) begin
      fetch_ip_d = ip_start;
    end
    if (flush_c) begin
      fetch_ip_d = jmp_addr;
      count_d    = '0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
    end else begin
      if (push_c) begin
        fetch_ip_d = fetch_ip_q + ADDR_W'(1);
        wr_ptr_d   = ~wr_ptr_q;
      end
      if (pop_c) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_pp_c;
    end
  end

  // Datapath registers and buffer storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_ip_q <= '0;
      count_q    <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      data_q     <= '{default: '0};
      addr_q     <= '{default: '0};
    end else begin
      fetch_ip_q <= fetch_ip_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (push_c) begin
        data_q[wr_ptr_q] <= mem_data;
        addr_q[wr_ptr_q] <= fetch_ip_q;
      end
    end
  end

endmodule
